// File: rtl/bcd_scan_display.sv
// Six-digit multiplexed seven-segment scanner for an HH:MM:SS BCD timer.
// Latches a per-frame snapshot, blanks leading hour zeros, blinks separators.
module bcd_scan_display #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] x5,
  input  logic [3:0] x4,
  input  logic [3:0] x3,
  input  logic [3:0] x2,
  input  logic [3:0] x1,
  input  logic [3:0] x0,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int HW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [HW-1:0] HC_MAX = HW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FC_MAX = FW'(BLINK_FRAMES - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          st, st_n;
  logic [2:0]      idx, idx_n;
  logic [HW-1:0]   hc, hc_n;
  logic [FW-1:0]   fc, fc_n;
  logic            bp, bp_n;
  logic [5:0][3:0] s, s_n;
  logic [6:0]      seg_n;
  logic            dp_n;
  logic [5:0]      an_n;
  logic            load, show;
  logic [3:0]      dig;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  endfunction

  always_comb begin
    st_n  = st;
    idx_n = idx;
    hc_n  = hc;
    fc_n  = fc;
    bp_n  = bp;
    s_n   = s;
    seg_n = seg;
    dp_n  = dp;
    an_n  = an;
    load  = 1'b0;
    show  = 1'b0;
    dig   = 4'd0;
    if (!en) begin
      st_n  = IDLE;
      idx_n = 3'd5;
      hc_n  = '0;
      fc_n  = '0;
      bp_n  = 1'b0;
      seg_n = '0;
      dp_n  = 1'b0;
      an_n  = '0;
    end else if (st == IDLE) begin
      st_n = SCAN;
      load = 1'b1;
    end else if (hc == HC_MAX) begin
      hc_n = '0;
      if (idx == 3'd0) begin
        load = 1'b1;
        if (fc == FC_MAX) begin
          fc_n = '0;
          bp_n = ~bp;
        end else begin
          fc_n = fc + 1'b1;
        end
      end else begin
        idx_n = idx - 3'd1;
        show  = 1'b1;
      end
    end else begin
      hc_n = hc + 1'b1;
    end
    // Frame start: capture inputs and decode digit 5 from them directly
    if (load) begin
      s_n   = {x5, x4, x3, x2, x1, x0};
      idx_n = 3'd5;
      hc_n  = '0;
      show  = 1'b1;
    end
    if (show) begin
      case (idx_n)
        3'd5:    dig = s_n[5];
        3'd4:    dig = s_n[4];
        3'd3:    dig = s_n[3];
        3'd2:    dig = s_n[2];
        3'd1:    dig = s_n[1];
        default: dig = s_n[0];
      endcase
      an_n  = 6'b1 << idx_n;
      seg_n = dec(dig);
      if (idx_n == 3'd5 && s_n[5] == 4'd0)
        seg_n = '0;
      if (idx_n == 3'd4 && s_n[5] == 4'd0 && s_n[4] == 4'd0)
        seg_n = '0;
      dp_n = bp_n && (idx_n == 3'd4 || idx_n == 3'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      idx <= 3'd5;
      hc  <= '0;
      fc  <= '0;
      bp  <= 1'b0;
      s   <= '0;
      seg <= '0;
      dp  <= 1'b0;
      an  <= '0;
    end else begin
      st  <= st_n;
      idx <= idx_n;
      hc  <= hc_n;
      fc  <= fc_n;
      bp  <= bp_n;
      s   <= s_n;
      seg <= seg_n;
      dp  <= dp_n;
      an  <= an_n;
    end
  end

endmodule
